// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants for the seven-segment scan driver.
//   NDIG       : number of multiplexed digits on the board
//   SEG_BLANK  : segment pattern with every segment off (active-low)
//   AN_OFF     : anode pattern with every digit off (active-low)
//   HEX7_TABLE : hex digit -> {g,f,e,d,c,b,a} active-low pattern, indexed by the nibble
package seg7_scan_driver_pkg;

    localparam int         NDIG      = 8;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [7:0] AN_OFF    = 8'hFF;

    // Packed so that HEX7_TABLE[n] selects the pattern for nibble n; the first
    // element of the concatenation is entry 15 (F).
    localparam logic [15:0][6:0] HEX7_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

endpackage

// File: rtl/seg7_scan_driver_hex_to_seg7.sv
// Combinational hex nibble to seven-segment decoder (active-low outputs).
//   nib_i : 4-bit hex value
//   seg_o : {g,f,e,d,c,b,a}, 0 = segment lit
module hex_to_seg7
    import seg7_scan_driver_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX7_TABLE[nib_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// Eight-digit multiplexed seven-segment scan driver showing a 32-bit word in hex.
// The word is captured into a shadow register only at frame boundaries so a scan
// never mixes old and new nibbles. A short guard interval after each digit advance
// keeps all anodes off to avoid ghosting; leading zeros may be suppressed.
//   clk         : system clock
//   rst         : asynchronous reset, active-low
//   value       : word to display, nibble i on digit i (digit 0 rightmost)
//   en          : 1 = scanning, 0 = dark with all counters frozen
//   an          : digit anodes, active-low
//   seg         : segments {g,f,e,d,c,b,a}, active-low
//   dp          : decimal point, active-low
//   frame_start : one-cycle pulse when the shadow word is reloaded
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int         DIV_MAX   = 99_999,
    parameter int         BLANK_CYC = 16,
    parameter int         BLANK_LZ  = 1,
    parameter logic [7:0] DP_MASK   = 8'h00
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] value,
    input  logic        en,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_start
);

    localparam int DW = (DIV_MAX   > 0) ? $clog2(DIV_MAX + 1)   : 1;
    localparam int GW = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;
    localparam logic [DW-1:0] DIV_LAST     = DW'(DIV_MAX);
    localparam logic [GW-1:0] GUARD_RELOAD = GW'(BLANK_CYC);

    // A guard at least as long as the dwell would keep every digit dark forever.
    if (BLANK_CYC > DIV_MAX) begin : g_bad_blank
        $error("seg7_scan_driver: BLANK_CYC (%0d) must not exceed DIV_MAX (%0d)", BLANK_CYC, DIV_MAX);
    end

    logic [DW-1:0] div_q,   div_d;
    logic [2:0]    idx_q,   idx_d;
    logic [GW-1:0] guard_q, guard_d;
    logic [31:0]   shadow_q, shadow_d;
    logic          frame_start_q, frame_start_d;
    logic [7:0]    an_q,  an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q,  dp_d;

    logic          tick;
    logic          frame_end;
    logic [3:0]    nibs [NDIG];
    logic [NDIG-1:0] upper_zero;
    logic [6:0]    seg_dec;
    logic          blanked;
    logic          dark;

    // Per-digit nibble and "this digit and everything above it is zero" flags.
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
        assign nibs[gi]       = shadow_q[4*gi +: 4];
        assign upper_zero[gi] = (shadow_q[31:4*gi] == '0);
    end

    hex_to_seg7 u_hex (
        .nib_i (nibs[idx_q]),
        .seg_o (seg_dec)
    );

    assign tick      = en && (div_q == DIV_LAST);
    assign frame_end = tick && (idx_q == 3'd7);
    assign blanked   = (BLANK_LZ != 0) && (idx_q != 3'd0) && upper_zero[idx_q];
    assign dark      = !en || (guard_q != '0) || blanked;

    always_comb begin
        div_d         = div_q;
        idx_d         = idx_q;
        guard_d       = guard_q;
        shadow_d      = shadow_q;
        frame_start_d = frame_end;

        if (en) begin
            div_d = tick ? '0 : div_q + 1'b1;
        end

        // The reload on a digit advance takes priority over the countdown.
        if (tick) begin
            idx_d   = idx_q + 3'd1;
            guard_d = GUARD_RELOAD;
        end else if (en && (guard_q != '0)) begin
            guard_d = guard_q - 1'b1;
        end

        if (frame_end) begin
            shadow_d = value;
        end
    end

    // Output decode uses this cycle's state; the registers present it next cycle.
    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (!dark) begin
            an_d  = AN_OFF ^ (8'h01 << idx_q);
            seg_d = seg_dec;
            dp_d  = ~DP_MASK[idx_q];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q         <= '0;
            idx_q         <= '0;
            guard_q       <= '0;
            shadow_q      <= '0;
            frame_start_q <= 1'b0;
            an_q          <= AN_OFF;
            seg_q         <= SEG_BLANK;
            dp_q          <= 1'b1;
        end else begin
            div_q         <= div_d;
            idx_q         <= idx_d;
            guard_q       <= guard_d;
            shadow_q      <= shadow_d;
            frame_start_q <= frame_start_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign dp          = dp_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver. Two instances share the stimulus:
// dut_a with leading-zero suppression and no decimal points, dut_b without
// suppression and the decimal point lit on digit 0.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [31:0] value;

    logic [7:0]  an_a,  an_b;
    logic [6:0]  seg_a, seg_b;
    logic        dp_a,  dp_b;
    logic        fs_a,  fs_b;

    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    int          chg_digit   = -1;
    logic [31:0] chg_value   = 32'h0;

    logic [7:0][6:0] es_num;
    logic [7:0][6:0] es_f;
    logic [7:0][6:0] es_a0;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .DIV_MAX   (3),
        .BLANK_CYC (1),
        .BLANK_LZ  (1),
        .DP_MASK   (8'h00)
    ) dut_a (
        .clk         (clk),
        .rst         (rst),
        .value       (value),
        .en          (en),
        .an          (an_a),
        .seg         (seg_a),
        .dp          (dp_a),
        .frame_start (fs_a)
    );

    seg7_scan_driver #(
        .DIV_MAX   (3),
        .BLANK_CYC (1),
        .BLANK_LZ  (0),
        .DP_MASK   (8'h01)
    ) dut_b (
        .clk         (clk),
        .rst         (rst),
        .value       (value),
        .en          (en),
        .an          (an_b),
        .seg         (seg_b),
        .dp          (dp_b),
        .frame_start (fs_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge (one rising edge has passed).
    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    // Check both instances for digit d; lit_x = 0 means that instance must be dark.
    task automatic check_out(input string tag, input logic lit_a, input logic lit_b,
                             input int d, input logic [6:0] s);
        logic [7:0] an_on;
        an_on = 8'hFF ^ (8'h01 << d);
        chk($sformatf("%s an_a", tag),  {24'h0, an_a},  {24'h0, lit_a ? an_on : 8'hFF});
        chk($sformatf("%s seg_a", tag), {25'h0, seg_a}, {25'h0, lit_a ? s : 7'h7F});
        chk($sformatf("%s dp_a", tag),  {31'h0, dp_a},  32'h1);
        chk($sformatf("%s an_b", tag),  {24'h0, an_b},  {24'h0, lit_b ? an_on : 8'hFF});
        chk($sformatf("%s seg_b", tag), {25'h0, seg_b}, {25'h0, lit_b ? s : 7'h7F});
        chk($sformatf("%s dp_b", tag),  {31'h0, dp_b},  {31'h0, (lit_b && d == 0) ? 1'b0 : 1'b1});
    endtask

    // One full frame starting right after a frame_start step: each digit is dark
    // for one cycle then lit for three; the last lit cycle of digit 7 carries the
    // next frame_start pulse.
    task automatic run_frame(input string tag, input logic [7:0][6:0] es,
                             input logic [7:0] lit_a, input logic [7:0] lit_b);
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 0) begin
                chk($sformatf("%s fs_a low", tag), {31'h0, fs_a}, 32'h0);
                chk($sformatf("%s fs_b low", tag), {31'h0, fs_b}, 32'h0);
            end
            check_out($sformatf("%s d%0d guard", tag, i), 1'b0, 1'b0, i, es[i]);
            for (int k = 0; k < 3; k++) begin
                step();
                check_out($sformatf("%s d%0d lit%0d", tag, i, k), lit_a[i], lit_b[i], i, es[i]);
                if (i == chg_digit && k == 0) value = chg_value;
            end
        end
        chk($sformatf("%s fs_a period", tag), {31'h0, fs_a}, 32'h1);
        chk($sformatf("%s fs_b period", tag), {31'h0, fs_b}, 32'h1);
    endtask

    initial begin
        // 12345678: digit i shows nibble i
        es_num[0] = 7'h00; es_num[1] = 7'h78; es_num[2] = 7'h02; es_num[3] = 7'h12;
        es_num[4] = 7'h19; es_num[5] = 7'h30; es_num[6] = 7'h24; es_num[7] = 7'h79;
        for (int i = 0; i < 8; i++) es_f[i] = 7'h0E;
        es_a0[0] = 7'h40; es_a0[1] = 7'h08;
        for (int i = 2; i < 8; i++) es_a0[i] = 7'h40;

        rst   = 1'b0;
        en    = 1'b1;
        value = 32'h0;
        step();
        step();
        chk("reset an_a",  {24'h0, an_a},  32'hFF);
        chk("reset seg_a", {25'h0, seg_a}, 32'h7F);
        chk("reset dp_a",  {31'h0, dp_a},  32'h1);
        chk("reset fs_a",  {31'h0, fs_a},  32'h0);
        chk("reset an_b",  {24'h0, an_b},  32'hFF);

        // Light digit 0, then drop reset between edges.
        rst = 1'b1;
        step();
        check_out("pre-async", 1'b1, 1'b1, 0, 7'h40);
        #2 rst = 1'b0;
        #1;
        chk("async an_a",  {24'h0, an_a},  32'hFF);
        chk("async seg_a", {25'h0, seg_a}, 32'h7F);
        chk("async dp_a",  {31'h0, dp_a},  32'h1);
        chk("async an_b",  {24'h0, an_b},  32'hFF);
        chk("async dp_b",  {31'h0, dp_b},  32'h1);
        chk("async fs_a",  {31'h0, fs_a},  32'h0);
        @(negedge clk);
        rst = 1'b1;
        cyc = 0;

        // value = 0: only digit 0 lights on dut_a.
        for (int k = 0; k < 4; k++) begin
            step();
            check_out($sformatf("zero d0 lit%0d", k), 1'b1, 1'b1, 0, 7'h40);
        end
        step();
        check_out("zero d1 guard", 1'b0, 1'b0, 1, 7'h40);
        step();
        check_out("zero d1 lz", 1'b0, 1'b1, 1, 7'h40);

        value = 32'h12345678;
        while (fs_a !== 1'b1 && cyc < 40) step();
        chk("first fs cycle", cyc, 32);
        chk("first fs_b", {31'h0, fs_b}, 32'h1);

        run_frame("num", es_num, 8'hFF, 8'hFF);

        // Change the word while digit 3 is showing; this frame must stay old.
        chg_digit = 3;
        chg_value = 32'hFFFFFFFF;
        run_frame("tear", es_num, 8'hFF, 8'hFF);
        chg_digit = -1;

        value = 32'h000000A0;
        run_frame("allf", es_f, 8'hFF, 8'hFF);

        run_frame("lz", es_a0, 8'h03, 8'hFF);

        // Pause mid-dwell on digit 0 for 10 cycles.
        cyc = 0;
        step();
        check_out("pause d0 guard", 1'b0, 1'b0, 0, 7'h40);
        step();
        check_out("pause d0 lit0", 1'b1, 1'b1, 0, 7'h40);
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            check_out($sformatf("pause off%0d", k), 1'b0, 1'b0, 0, 7'h40);
            chk($sformatf("pause off%0d fs_a", k), {31'h0, fs_a}, 32'h0);
        end
        en = 1'b1;
        for (int k = 1; k < 3; k++) begin
            step();
            check_out($sformatf("resume d0 lit%0d", k), 1'b1, 1'b1, 0, 7'h40);
        end
        step();
        check_out("resume d1 guard", 1'b0, 1'b0, 1, 7'h08);
        for (int k = 0; k < 3; k++) begin
            step();
            check_out($sformatf("resume d1 lit%0d", k), 1'b1, 1'b1, 1, 7'h08);
        end
        while (fs_a !== 1'b1 && cyc < 60) step();
        chk("pause fs cycle", cyc, 42);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
